// File: rtl/bip_pkg.sv
// Shared encodings for the BIP-I accumulator CPU: opcodes, mux selects,
// ALU operations and the bundle of control strobes produced by the decoder.
package bip_pkg;

  localparam int NB_OPCODE = 5;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'd0;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'd1;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'd2;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'd3;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'd4;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'd5;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'd6;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'd7;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  localparam logic SELB_RAM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef struct packed {
    logic       wr_pc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{wr_pc: 1'b0, sel_a: SELA_RAM, sel_b: SELB_RAM,
                                  wr_acc: 1'b0, op: ALU_ADD, wr_ram: 1'b0, rd_ram: 1'b0};

endpackage

// File: rtl/instruction_decoder.sv
// BIP-I control unit: zero-latency opcode decode into datapath strobes, with a
// sticky halt flag that silences every strobe after HLT or an undefined opcode.
module instruction_decoder
  import bip_pkg::*;
#(
  parameter int NB_OPCODE = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NB_OPCODE-1:0] i_opcode,
  output logic                 o_WrPC,
  output logic [1:0]           o_SelA,
  output logic                 o_SelB,
  output logic                 o_WrAcc,
  output logic                 o_op,
  output logic                 o_WrRam,
  output logic                 o_RdRam
);

  logic  r_halt;
  logic  w_stop;
  ctrl_t w_dec;
  ctrl_t w_ctrl;

  // Decode the opcode; HLT and undefined opcodes raise w_stop.
  always_comb begin
    w_dec  = CTRL_IDLE;
    w_stop = 1'b0;
    case (i_opcode)
      OP_HLT:  w_stop = 1'b1;
      OP_STO:  begin w_dec.wr_pc = 1'b1; w_dec.wr_ram = 1'b1; end
      OP_LD:   begin w_dec.wr_pc = 1'b1; w_dec.wr_acc = 1'b1; w_dec.rd_ram = 1'b1; end
      OP_LDI:  begin w_dec.wr_pc = 1'b1; w_dec.sel_a = SELA_IMM; w_dec.wr_acc = 1'b1; end
      OP_ADD:  begin
        w_dec.wr_pc = 1'b1; w_dec.sel_a = SELA_ALU; w_dec.wr_acc = 1'b1;
        w_dec.op = ALU_ADD; w_dec.rd_ram = 1'b1;
      end
      OP_ADDI: begin
        w_dec.wr_pc = 1'b1; w_dec.sel_a = SELA_ALU; w_dec.sel_b = SELB_IMM;
        w_dec.wr_acc = 1'b1; w_dec.op = ALU_ADD;
      end
      OP_SUB:  begin
        w_dec.wr_pc = 1'b1; w_dec.sel_a = SELA_ALU; w_dec.wr_acc = 1'b1;
        w_dec.op = ALU_SUB; w_dec.rd_ram = 1'b1;
      end
      OP_SUBI: begin
        w_dec.wr_pc = 1'b1; w_dec.sel_a = SELA_ALU; w_dec.sel_b = SELB_IMM;
        w_dec.wr_acc = 1'b1; w_dec.op = ALU_SUB;
      end
      default: w_stop = 1'b1;
    endcase
  end

  // Sticky halt flag; reset takes priority over a simultaneous HLT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_halt <= 1'b0;
    end else if (w_stop) begin
      r_halt <= 1'b1;
    end else begin
      r_halt <= r_halt;
    end
  end

  // Reset or halt gate every strobe immediately.
  always_comb begin
    if (i_rst || r_halt) begin
      w_ctrl = CTRL_IDLE;
    end else begin
      w_ctrl = w_dec;
    end
  end

  assign o_WrPC  = w_ctrl.wr_pc;
  assign o_SelA  = w_ctrl.sel_a;
  assign o_SelB  = w_ctrl.sel_b;
  assign o_WrAcc = w_ctrl.wr_acc;
  assign o_op    = w_ctrl.op;
  assign o_WrRam = w_ctrl.wr_ram;
  assign o_RdRam = w_ctrl.rd_ram;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed scenarios plus random
// opcode/reset traffic compared against a table-driven reference with a halt bit.
module tb_instruction_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic       wr_pc, sel_b, wr_acc, alu_op, wr_ram, rd_ram;
  logic [1:0] sel_a;
  logic [7:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tbl [0:7];
  bit         m_halt;

  always #5 clk = ~clk;

  instruction_decoder #(.NB_OPCODE(5)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_opcode(opcode),
    .o_WrPC  (wr_pc),
    .o_SelA  (sel_a),
    .o_SelB  (sel_b),
    .o_WrAcc (wr_acc),
    .o_op    (alu_op),
    .o_WrRam (wr_ram),
    .o_RdRam (rd_ram)
  );

  // {WrPC, SelA[1:0], SelB, WrAcc, op, WrRam, RdRam}
  assign dut_vec = {wr_pc, sel_a, sel_b, wr_acc, alu_op, wr_ram, rd_ram};

  function automatic logic [7:0] model_out(input logic [4:0] op, input logic r, input bit h);
    if (r || h || op > 5'd7) return 8'h00;
    return tbl[op[2:0]];
  endfunction

  // Advance one clock edge and update the reference halt bit from the inputs seen there.
  task automatic tick();
    @(posedge clk);
    if (rst) m_halt = 1'b0;
    else if (opcode == 5'd0 || opcode > 5'd7) m_halt = 1'b1;
    #1;
  endtask

  // Strobe exclusivity and legal SelA, every cycle.
  always @(negedge clk) begin
    n_checks++;
    if ((wr_ram & rd_ram) !== 1'b0 || (wr_ram & wr_acc) !== 1'b0 || sel_a === 2'b11 || $isunknown(sel_a)) begin
      n_fail++;
      $display("FAIL invariant: WrRam=%b RdRam=%b WrAcc=%b SelA=%b, required exclusive strobes and SelA!=11",
               wr_ram, rd_ram, wr_acc, sel_a);
    end
  end

  task automatic test_reset();
    rst = 1'b1; opcode = 5'b00100;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 8'h00) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", dut_vec, 8'h00); end
    tick();
    rst = 1'b0; opcode = 5'b00100;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 8'b1100_1001) begin n_fail++; $display("FAIL after_reset_add: got %b want %b", dut_vec, 8'b1100_1001); end
    tick();
  endtask

  task automatic test_sweep();
    for (int op = 1; op <= 7; op++) begin
      opcode = 5'(op);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_out(opcode, rst, m_halt)) begin
        n_fail++;
        $display("FAIL sweep op=%0d: got %b want %b", op, dut_vec, model_out(opcode, rst, m_halt));
      end
      tick();
    end
  endtask

  task automatic test_hlt();
    opcode = 5'b00000;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 8'h00) begin n_fail++; $display("FAIL hlt_outputs: got %b want %b", dut_vec, 8'h00); end
    tick();
    opcode = 5'b00010;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 8'h00) begin n_fail++; $display("FAIL halted_ld: got %b want %b", dut_vec, 8'h00); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; opcode = 5'b00010;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 8'b1000_1001) begin n_fail++; $display("FAIL resume_ld: got %b want %b", dut_vec, 8'b1000_1001); end
    tick();
  endtask

  task automatic test_undefined();
    opcode = 5'b01000;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 8'h00) begin n_fail++; $display("FAIL undef_outputs: got %b want %b", dut_vec, 8'h00); end
    tick();
    opcode = 5'b00011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== 8'h00) begin n_fail++; $display("FAIL undef_sticky cyc=%0d: got %b want %b", i, dut_vec, 8'h00); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 8'b1010_1000) begin n_fail++; $display("FAIL undef_resume_ldi: got %b want %b", dut_vec, 8'b1010_1000); end
    tick();
  endtask

  task automatic test_reset_vs_hlt();
    rst = 1'b1; opcode = 5'b00000;
    tick();
    rst = 1'b0; opcode = 5'b00101;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 8'b1101_1000) begin n_fail++; $display("FAIL rst_beats_hlt: got %b want %b", dut_vec, 8'b1101_1000); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 7) == 0);
      opcode = ($urandom_range(0, 11) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 7));
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_out(opcode, rst, m_halt)) begin
        n_fail++;
        $display("FAIL random i=%0d op=%0d rst=%b: got %b want %b",
                 i, opcode, rst, dut_vec, model_out(opcode, rst, m_halt));
      end
      tick();
    end
  endtask

  initial begin
    tbl[0] = 8'b0000_0000;
    tbl[1] = 8'b1000_0010;
    tbl[2] = 8'b1000_1001;
    tbl[3] = 8'b1010_1000;
    tbl[4] = 8'b1100_1001;
    tbl[5] = 8'b1101_1000;
    tbl[6] = 8'b1100_1101;
    tbl[7] = 8'b1101_1100;
    m_halt = 1'b0;
    rst    = 1'b1;
    opcode = 5'b00100;

    test_reset();
    test_sweep();
    test_hlt();
    test_undefined();
    test_reset_vs_hlt();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
